// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline with a data-memory wait FSM and timeout error.
// Optional performance counters are built when STALL_PERF_EN is defined.
module pipeline_stall_controller #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8,
    parameter int PERF_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_use_hazard,
    input  logic              branch_taken_EX,
    input  logic              imem_ready,
    input  logic              dmem_req_MEM,
    input  logic              dmem_ready,
    input  logic              err_clear,
    output logic              PCWrite,
    output logic              Write_IFID,
    output logic              Write_IDEX,
    output logic              Write_EXMEM,
    output logic              Write_MEMWB,
    output logic              flush_IFID,
    output logic              flush_IDEX,
    output logic              bubble_MEMWB,
    output logic              dmem_valid,
    output logic              mem_timeout_err,
    output logic [1:0]        ctrl_state,
    output logic [PERF_W-1:0] perf_stall_cycles,
    output logic [PERF_W-1:0] perf_flush_count
);

    typedef enum logic [1:0] {
        S_RUN  = 2'b00,
        S_WAIT = 2'b01,
        S_ERR  = 2'b10
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q;
    logic [CNT_W-1:0] wait_cnt_q;
    logic             err_q;
    logic             mstall;

    assign mstall          = dmem_valid & ~dmem_ready;
    assign ctrl_state      = state_q;
    assign mem_timeout_err = err_q;

    // Memory stall outranks everything; a taken branch squashes ID, so it outranks load-use and fetch.
    always_comb begin
        PCWrite      = 1'b1;
        Write_IFID   = 1'b1;
        Write_IDEX   = 1'b1;
        Write_EXMEM  = 1'b1;
        Write_MEMWB  = 1'b1;
        flush_IFID   = 1'b0;
        flush_IDEX   = 1'b0;
        bubble_MEMWB = 1'b0;
        dmem_valid   = dmem_req_MEM & (state_q != S_ERR);
        if (!rst_n) begin
            {PCWrite, Write_IFID, Write_IDEX, Write_EXMEM, Write_MEMWB} = 5'b0;
            {flush_IFID, flush_IDEX, bubble_MEMWB} = 3'b111;
            dmem_valid = 1'b0;
        end else if (state_q == S_ERR) begin
            {PCWrite, Write_IFID, Write_IDEX, Write_EXMEM, Write_MEMWB} = 5'b0;
        end else if (mstall) begin
            {PCWrite, Write_IFID, Write_IDEX, Write_EXMEM} = 4'b0;
            bubble_MEMWB = 1'b1;
        end else if (branch_taken_EX) begin
            flush_IFID = 1'b1;
            flush_IDEX = 1'b1;
        end else if (load_use_hazard) begin
            PCWrite    = 1'b0;
            Write_IFID = 1'b0;
            flush_IDEX = 1'b1;
        end else if (!imem_ready) begin
            PCWrite    = 1'b0;
            flush_IFID = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (mstall) begin
                        state_q    <= S_WAIT;
                        wait_cnt_q <= '0;
                    end
                end
                S_WAIT: begin
                    if (dmem_ready || !dmem_req_MEM) begin
                        state_q    <= S_RUN;
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q == CNT_LAST) begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                S_ERR: begin
                    if (err_clear) begin
                        state_q    <= S_RUN;
                        err_q      <= 1'b0;
                        wait_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q    <= S_RUN;
                    wait_cnt_q <= '0;
                end
            endcase
        end
    end

`ifdef STALL_PERF_EN
    logic [PERF_W-1:0] perf_stall_q;
    logic [PERF_W-1:0] perf_flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else if (err_clear) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (!PCWrite && state_q != S_ERR)
                perf_stall_q <= perf_stall_q + 1'b1;
            if (flush_IFID || flush_IDEX)
                perf_flush_q <= perf_flush_q + 1'b1;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flush_count  = perf_flush_q;
`else
    assign perf_stall_cycles = '0;
    assign perf_flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: directed literal checks plus random stimulus
// compared every cycle against a rule-level model of the stall/flush priorities.
module tb_pipeline_stall_controller;
    localparam int T  = 4;
    localparam int PW = 32;

    logic clk = 1'b0;
    logic rst_n, lu, br, imem, req, rdy, eclr;
    logic PCWrite, Write_IFID, Write_IDEX, Write_EXMEM, Write_MEMWB;
    logic flush_IFID, flush_IDEX, bubble_MEMWB, dmem_valid, mem_timeout_err;
    logic [1:0]    ctrl_state;
    logic [PW-1:0] perf_stall_cycles, perf_flush_count;

    always #5 clk = ~clk;

    pipeline_stall_controller #(.TIMEOUT_CYCLES(T), .CNT_W(8), .PERF_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .load_use_hazard(lu), .branch_taken_EX(br),
        .imem_ready(imem), .dmem_req_MEM(req), .dmem_ready(rdy), .err_clear(eclr),
        .PCWrite(PCWrite), .Write_IFID(Write_IFID), .Write_IDEX(Write_IDEX),
        .Write_EXMEM(Write_EXMEM), .Write_MEMWB(Write_MEMWB), .flush_IFID(flush_IFID),
        .flush_IDEX(flush_IDEX), .bubble_MEMWB(bubble_MEMWB), .dmem_valid(dmem_valid),
        .mem_timeout_err(mem_timeout_err), .ctrl_state(ctrl_state),
        .perf_stall_cycles(perf_stall_cycles), .perf_flush_count(perf_flush_count)
    );

    int total = 0;
    int bad   = 0;

    // Model: mode 0 run, 1 waiting on memory, 2 error; m_n counts wait cycles spent so far.
    logic [1:0]    m_mode;
    int            m_n;
    logic          m_err;
    logic [PW-1:0] m_ps, m_pf;

    // Vector: {PC,IFID,IDEX,EXMEM,MEMWB, flushIFID,flushIDEX, bubble, dvalid, err, state[1:0]}
    function automatic logic [11:0] model_out();
        logic [4:0] en;
        logic [1:0] fl;
        logic       bub, dv, ms;
        en = 5'b11111; fl = 2'b00; bub = 1'b0; dv = 1'b0;
        if (!rst_n) begin
            en = 5'b0; fl = 2'b11; bub = 1'b1;
        end else if (m_mode == 2'd2) begin
            en = 5'b0;
        end else begin
            dv = req;
            ms = req && !rdy;
            if (ms) begin
                en = 5'b00001; bub = 1'b1;
            end else if (br) fl = 2'b11;
            else if (lu) begin
                en = 5'b00111; fl = 2'b01;
            end else if (!imem) begin
                en = 5'b01111; fl = 2'b10;
            end
        end
        return {en, fl, bub, dv, m_err, m_mode};
    endfunction

    function automatic logic [11:0] dut_out();
        return {PCWrite, Write_IFID, Write_IDEX, Write_EXMEM, Write_MEMWB,
                flush_IFID, flush_IDEX, bubble_MEMWB, dmem_valid, mem_timeout_err, ctrl_state};
    endfunction

    task automatic model_reset();
        m_mode = 2'd0; m_n = 0; m_err = 1'b0; m_ps = '0; m_pf = '0;
    endtask

    task automatic model_tick();
        logic [11:0] e;
        e = model_out();
        if (!rst_n) begin
            model_reset();
            return;
        end
`ifdef STALL_PERF_EN
        if (eclr) begin
            m_ps = '0; m_pf = '0;
        end else begin
            if (!e[11] && m_mode != 2'd2) m_ps = m_ps + 1;
            if (e[6] || e[5]) m_pf = m_pf + 1;
        end
`endif
        if (m_mode == 2'd2) begin
            if (eclr) begin
                m_mode = 2'd0; m_err = 1'b0; m_n = 0;
            end
        end else if (m_mode == 2'd0) begin
            if (req && !rdy) begin
                m_mode = 2'd1; m_n = 0;
            end
        end else begin
            if (rdy || !req) begin
                m_mode = 2'd0; m_n = 0;
            end else begin
                m_n++;
                if (m_n >= T) begin
                    m_mode = 2'd2; m_err = 1'b1;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_perf(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: compare at negedge against model (and optional literal), then advance model.
    task automatic cyc(input string name, input bit use_lit, input logic [11:0] lit);
        @(negedge clk);
        chk({name, "/model"}, dut_out(), model_out());
        chk_perf({name, "/stall_ctr"}, perf_stall_cycles, m_ps);
        chk_perf({name, "/flush_ctr"}, perf_flush_count, m_pf);
        if (use_lit) chk({name, "/lit"}, dut_out(), lit);
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic set_in(input logic l, input logic b, input logic im, input logic rq,
                          input logic rd, input logic ec);
        lu = l; br = b; imem = im; req = rq; rdy = rd; eclr = ec;
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        set_in(1, 1, 0, 1, 0, 1);
        #2;
        cyc("reset", 1, 12'b00000_11_1_0_0_00);
        rst_n = 1'b1;
        set_in(0, 0, 1, 0, 0, 0);
        cyc("release", 1, 12'b11111_00_0_0_0_00);

        set_in(1, 0, 1, 0, 0, 0);
        cyc("loaduse", 1, 12'b00111_01_0_0_0_00);
        set_in(0, 0, 1, 0, 0, 0);
        cyc("after_lu", 1, 12'b11111_00_0_0_0_00);

        set_in(0, 0, 1, 1, 0, 0);
        cyc("mwait1", 1, 12'b00001_00_1_1_0_00);
        cyc("mwait2", 1, 12'b00001_00_1_1_0_01);
        cyc("mwait3", 1, 12'b00001_00_1_1_0_01);
        set_in(0, 0, 1, 1, 1, 0);
        cyc("mdone", 1, 12'b11111_00_0_1_0_01);
        set_in(0, 0, 1, 0, 0, 0);
        cyc("mback", 1, 12'b11111_00_0_0_0_00);
        set_in(0, 0, 1, 1, 1, 0);
        cyc("zerowait", 1, 12'b11111_00_0_1_0_00);
        set_in(0, 0, 0, 0, 0, 0);
        cyc("nofetch", 1, 12'b01111_10_0_0_0_00);

        set_in(1, 1, 1, 0, 0, 0);
        cyc("br_over_lu", 1, 12'b11111_11_0_0_0_00);
        set_in(1, 1, 0, 1, 0, 0);
        cyc("mstall_wins", 1, 12'b00001_00_1_1_0_00);
        set_in(0, 0, 1, 1, 0, 0);
        for (int i = 0; i < T; i++) cyc("timeout_wait", 1, 12'b00001_00_1_1_0_01);
        cyc("error", 1, 12'b00000_00_0_0_1_10);
        set_in(0, 0, 1, 1, 0, 1);
        cyc("err_clear", 1, 12'b00000_00_0_0_1_10);
        set_in(0, 0, 1, 0, 0, 0);
        cyc("cleared", 1, 12'b11111_00_0_0_0_00);

        // Reset asserted while waiting on memory.
        set_in(0, 0, 1, 1, 0, 0);
        cyc("pre_rst1", 0, '0);
        cyc("pre_rst2", 0, '0);
        rst_n = 1'b0;
        model_reset();
        cyc("rst_midwait", 1, 12'b00000_11_1_0_0_00);
        rst_n = 1'b1;
        set_in(0, 0, 1, 0, 0, 0);
        cyc("post_rst", 1, 12'b11111_00_0_0_0_00);

        // Two load-use cycles and one branch for the counters.
        set_in(1, 0, 1, 0, 0, 0);
        cyc("perf_lu1", 0, '0);
        cyc("perf_lu2", 0, '0);
        set_in(0, 1, 1, 0, 0, 0);
        cyc("perf_br", 0, '0);
        set_in(0, 0, 1, 0, 0, 0);
        @(negedge clk);
`ifdef STALL_PERF_EN
        chk_perf("perf_stall_lit", perf_stall_cycles, 2);
        chk_perf("perf_flush_lit", perf_flush_count, 3);
`else
        chk_perf("perf_stall_lit", perf_stall_cycles, 0);
        chk_perf("perf_flush_lit", perf_flush_count, 0);
`endif
        @(posedge clk);
        model_tick();
        #1;

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(99) < 2) begin
                rst_n = 1'b0;
                model_reset();
            end else begin
                rst_n = 1'b1;
            end
            set_in(1'($urandom_range(99) < 25), 1'($urandom_range(99) < 20),
                   1'($urandom_range(99) < 80), 1'($urandom_range(99) < 75),
                   1'($urandom_range(99) < 30), 1'($urandom_range(99) < 10));
            cyc("random", 0, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
